// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker
// Tracks live per-lane vehicle queue counts. Arrivals come from edge-detected
// loop sensors. Departures come from a per-lane timer that releases one car
// every DEPART_CYCLES clocks while the lane is green.
// The counters drive the packed lane bus directly. The busiest-lane one-hot
// and the total count are registered one cycle behind the counters.
// Optional build macro: LANE_OVF_FLAG_EN adds sticky per-lane overflow flags
// (ovf) that record arrivals lost to counter saturation.
module lane_queue_tracker #(
  parameter int NUM_LANES     = 8,
  parameter int CNT_W         = 8,
  parameter int DEPART_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_LANES-1:0]                sensor,
  input  logic [NUM_LANES-1:0]                green,
  input  logic [NUM_LANES-1:0]                clear_lane,
  output logic [NUM_LANES*CNT_W-1:0]          lanes,
  output logic [NUM_LANES-1:0]                busiest,
`ifdef LANE_OVF_FLAG_EN
  output logic [NUM_LANES-1:0]                ovf,
`endif
  output logic [CNT_W+$clog2(NUM_LANES)-1:0]  total
);

  localparam int TMR_W = $clog2(DEPART_CYCLES) + 1;
  localparam int TOT_W = CNT_W + $clog2(NUM_LANES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [NUM_LANES-1:0] r_sensor_q;
  logic [CNT_W-1:0]     r_cnt [NUM_LANES];
  logic [TMR_W-1:0]     r_tmr [NUM_LANES];
  logic [NUM_LANES-1:0] r_busiest;
  logic [TOT_W-1:0]     r_total;

  logic [NUM_LANES-1:0] w_arr;
  logic [NUM_LANES-1:0] w_tick;
  logic [NUM_LANES-1:0] w_dep;
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_LANES];
  logic [TMR_W-1:0]     w_tmr_nxt [NUM_LANES];
  logic [NUM_LANES-1:0] w_busiest_nxt;
  logic [TOT_W-1:0]     w_total_nxt;
  logic [CNT_W-1:0]     w_max;

`ifdef LANE_OVF_FLAG_EN
  logic [NUM_LANES-1:0] r_ovf;
  logic [NUM_LANES-1:0] w_drop;
`endif

  // Rising edge of each loop sensor is one arrival; a held-high sensor counts once
  always_comb begin
    w_arr = sensor & ~r_sensor_q;
  end

  // Departure timers: run while green, wrap on the last step, and fire a
  // departure only when the lane has a car to release
  always_comb begin
    w_tick = '0;
    w_dep  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_tmr_nxt[i] = '0;
      if (green[i]) begin
        if (r_tmr[i] == TMR_LAST) begin
          w_tick[i]    = 1'b1;
          w_tmr_nxt[i] = '0;
        end else begin
          w_tmr_nxt[i] = r_tmr[i] + TMR_W'(1);
        end
      end
      w_dep[i] = w_tick[i] && (r_cnt[i] != '0);
    end
  end

  // Counter update: clear beats everything, a matched arrival/departure
  // cancels, and arrivals saturate at full scale instead of wrapping
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (clear_lane[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_arr[i] && w_dep[i]) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_arr[i]) begin
        if (r_cnt[i] != CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else if (w_dep[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
    end
  end

`ifdef LANE_OVF_FLAG_EN
  // An arrival is lost only when it is not cancelled by a departure, the lane
  // is not being cleared, and the counter is already at full scale
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_drop[i] = w_arr[i] && !w_dep[i] && !clear_lane[i] && (r_cnt[i] == CNT_MAX);
    end
  end
`endif

  // Busiest lane (strictly greater wins, so ties keep the lowest index and
  // all-zero counts give no winner) and the full-width sum of all lanes
  always_comb begin
    w_max         = '0;
    w_busiest_nxt = '0;
    w_total_nxt   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_total_nxt = w_total_nxt + TOT_W'(r_cnt[i]);
      if (r_cnt[i] > w_max) begin
        w_max            = r_cnt[i];
        w_busiest_nxt    = '0;
        w_busiest_nxt[i] = 1'b1;
      end
    end
  end

  // State registers; the sensor history is loaded during reset so a sensor
  // already high when reset releases does not look like a new arrival
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sensor_q <= sensor;
      r_busiest  <= '0;
      r_total    <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_cnt[i] <= '0;
        r_tmr[i] <= '0;
      end
    end else begin
      r_sensor_q <= sensor;
      r_busiest  <= w_busiest_nxt;
      r_total    <= w_total_nxt;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_tmr[i] <= w_tmr_nxt[i];
      end
    end
  end

`ifdef LANE_OVF_FLAG_EN
  // Sticky overflow flags; a lane clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf | w_drop) & ~clear_lane;
    end
  end

  assign ovf = r_ovf;
`endif

  // Lane bus is a direct view of the counter registers
  always_comb begin
    lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  assign busiest = r_busiest;
  assign total   = r_total;

endmodule

// File: tb/tb_lane_queue_tracker.sv
// tb_lane_queue_tracker
// Directed scenarios for the lane queue tracker followed by a long randomized
// run, all compared against a behavioural queue model kept in the bench.
// Build with LANE_OVF_FLAG_EN defined to include the overflow flag checks.
module tb_lane_queue_tracker;

  localparam int DC     = 4;
  localparam int CNTMAX = 255;

  logic        clk;
  logic        rst;
  logic [7:0]  sensor;
  logic [7:0]  green;
  logic [7:0]  clear_lane;
  logic [63:0] lanes;
  logic [7:0]  busiest;
  logic [10:0] total;
`ifdef LANE_OVF_FLAG_EN
  logic [7:0]  ovf;
  logic [7:0]  mOvf;
`endif

  int          mCnt [8];
  int          mRun [8];
  logic [7:0]  mPrev;
  logic [7:0]  mBusy;
  int          mTot;

  int          vectors;
  int          errors;

  lane_queue_tracker #(
    .NUM_LANES     (8),
    .CNT_W         (8),
    .DEPART_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor     (sensor),
    .green      (green),
    .clear_lane (clear_lane),
    .lanes      (lanes),
    .busiest    (busiest),
`ifdef LANE_OVF_FLAG_EN
    .ovf        (ovf),
`endif
    .total      (total)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue counts per lane; a green lane releases a car on
  // every DC-th consecutive green cycle, and the busiest/total outputs report
  // the counts as they stood before the current edge
  task automatic modelStep();
    int  best;
    bit  arr;
    bit  dep;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        mCnt[i] = 0;
        mRun[i] = 0;
      end
      mPrev = sensor;
      mBusy = 8'h00;
      mTot  = 0;
`ifdef LANE_OVF_FLAG_EN
      mOvf  = 8'h00;
`endif
    end else begin
      best  = 0;
      mBusy = 8'h00;
      mTot  = 0;
      for (int i = 0; i < 8; i++) begin
        mTot = mTot + mCnt[i];
        if (mCnt[i] > best) begin
          best  = mCnt[i];
          mBusy = 8'(1) << i;
        end
      end
      for (int i = 0; i < 8; i++) begin
        arr = sensor[i] && !mPrev[i];
        if (green[i]) mRun[i] = mRun[i] + 1;
        else          mRun[i] = 0;
        dep = green[i] && (mRun[i] % DC == 0) && (mCnt[i] > 0);
        if (clear_lane[i]) begin
          mCnt[i] = 0;
`ifdef LANE_OVF_FLAG_EN
          mOvf[i] = 1'b0;
`endif
        end else if (arr && dep) begin
          mCnt[i] = mCnt[i];
        end else if (arr) begin
          if (mCnt[i] == CNTMAX) begin
`ifdef LANE_OVF_FLAG_EN
            mOvf[i] = 1'b1;
`endif
          end else begin
            mCnt[i] = mCnt[i] + 1;
          end
        end else if (dep) begin
          mCnt[i] = mCnt[i] - 1;
        end
      end
      mPrev = sensor;
    end
  endtask

  function automatic logic [63:0] expLanes();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(mCnt[i]);
    return v;
  endfunction

  // One clock: model follows the edge, outputs are then sampled 1 time unit later
  task automatic doCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst        = 1'b0;
    sensor     = 8'h00;
    green      = 8'h00;
    clear_lane = 8'h00;
    doCycle();
    rst = 1'b1;
  endtask

  task automatic pulseLanes(input logic [7:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      sensor = mask;
      doCycle();
      sensor = 8'h00;
      doCycle();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    sensor     = 8'hFF;
    green      = 8'h00;
    clear_lane = 8'h00;
    doCycle();
    doCycle();
    rst = 1'b1;
    doCycle();
    vectors++;
    if (lanes !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_lanes: got %h expected %h", lanes, 64'h0);
    end
    vectors++;
    if (busiest !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_busiest: got %h expected %h", busiest, 8'h00);
    end
    vectors++;
    if (total !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_total: got %0d expected %0d", total, 0);
    end
    for (int k = 0; k < 4; k++) doCycle();
    vectors++;
    if (lanes !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_held_sensor: got %h expected %h", lanes, 64'h0);
    end
`ifdef LANE_OVF_FLAG_EN
    vectors++;
    if (ovf !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %h expected %h", ovf, 8'h00);
    end
`endif
  endtask

  task automatic test_arrivals();
    doReset();
    for (int k = 0; k < 48; k++) begin
      sensor = (k < 15) ? 8'h81 : 8'h80;
      doCycle();
      if (k == 47) begin
        vectors++;
        if (total !== 11'd62) begin
          errors++;
          $display("[TB] FAIL arr_total_lag: got %0d expected %0d", total, 62);
        end
      end
      sensor = 8'h00;
      doCycle();
    end
    vectors++;
    if (lanes[63:56] !== 8'h30) begin
      errors++;
      $display("[TB] FAIL arr_lane7: got %h expected %h", lanes[63:56], 8'h30);
    end
    vectors++;
    if (lanes[7:0] !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL arr_lane0: got %h expected %h", lanes[7:0], 8'h0F);
    end
    vectors++;
    if (total !== 11'd63) begin
      errors++;
      $display("[TB] FAIL arr_total: got %0d expected %0d", total, 63);
    end
    vectors++;
    if (busiest !== 8'b1000_0000) begin
      errors++;
      $display("[TB] FAIL arr_busiest: got %b expected %b", busiest, 8'b1000_0000);
    end
    vectors++;
    if (lanes !== expLanes()) begin
      errors++;
      $display("[TB] FAIL arr_model: got %h expected %h", lanes, expLanes());
    end
  endtask

  task automatic test_departure();
    int expv;
    doReset();
    pulseLanes(8'h20, 3);
    green = 8'b0010_0000;
    for (int k = 1; k <= 14; k++) begin
      doCycle();
      expv = 3 - ((k / 4 > 3) ? 3 : k / 4);
      vectors++;
      if (lanes[47:40] !== 8'(expv)) begin
        errors++;
        $display("[TB] FAIL dep_rate cyc %0d: got %0d expected %0d", k, lanes[47:40], expv);
      end
    end
    green = 8'h00;
    doReset();
    pulseLanes(8'h20, 3);
    green = 8'b0010_0000;
    for (int k = 0; k < 6; k++) doCycle();
    green = 8'h00;
    doCycle();
    doCycle();
    vectors++;
    if (lanes[47:40] !== 8'd2) begin
      errors++;
      $display("[TB] FAIL dep_green_drop: got %0d expected %0d", lanes[47:40], 2);
    end
    green = 8'b0010_0000;
    for (int k = 0; k < 3; k++) doCycle();
    vectors++;
    if (lanes[47:40] !== 8'd2) begin
      errors++;
      $display("[TB] FAIL dep_restart_early: got %0d expected %0d", lanes[47:40], 2);
    end
    doCycle();
    vectors++;
    if (lanes[47:40] !== 8'd1) begin
      errors++;
      $display("[TB] FAIL dep_restart: got %0d expected %0d", lanes[47:40], 1);
    end
    green = 8'h00;
  endtask

  task automatic test_simultaneous();
    doReset();
    pulseLanes(8'h08, 10);
    green = 8'h08;
    for (int k = 0; k < 3; k++) doCycle();
    sensor = 8'h08;
    doCycle();
    vectors++;
    if (lanes[31:24] !== 8'd10) begin
      errors++;
      $display("[TB] FAIL sim_arr_dep: got %0d expected %0d", lanes[31:24], 10);
    end
    sensor = 8'h00;
    for (int k = 0; k < 3; k++) doCycle();
    sensor     = 8'h08;
    clear_lane = 8'h08;
    doCycle();
    sensor     = 8'h00;
    clear_lane = 8'h00;
    vectors++;
    if (lanes[31:24] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sim_clear: got %0d expected %0d", lanes[31:24], 0);
    end
    for (int k = 0; k < 5; k++) doCycle();
    vectors++;
    if (lanes[31:24] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sim_empty_green: got %0d expected %0d", lanes[31:24], 0);
    end
    green = 8'h00;
  endtask

  task automatic test_saturation();
    doReset();
    pulseLanes(8'h04, 255);
    vectors++;
    if (lanes[23:16] !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_255: got %0d expected %0d", lanes[23:16], 255);
    end
`ifdef LANE_OVF_FLAG_EN
    vectors++;
    if (ovf[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_ovf_early: got %b expected %b", ovf[2], 1'b0);
    end
`endif
    pulseLanes(8'h04, 1);
`ifdef LANE_OVF_FLAG_EN
    vectors++;
    if (ovf[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_ovf_set: got %b expected %b", ovf[2], 1'b1);
    end
`endif
    pulseLanes(8'h04, 4);
    vectors++;
    if (lanes[23:16] !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_hold: got %0d expected %0d", lanes[23:16], 255);
    end
    vectors++;
    if (total !== 11'd255) begin
      errors++;
      $display("[TB] FAIL sat_total: got %0d expected %0d", total, 255);
    end
    clear_lane = 8'h04;
    doCycle();
    clear_lane = 8'h00;
    vectors++;
    if (lanes[23:16] !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_clear: got %0d expected %0d", lanes[23:16], 0);
    end
`ifdef LANE_OVF_FLAG_EN
    vectors++;
    if (ovf[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_ovf_clear: got %b expected %b", ovf[2], 1'b0);
    end
`endif
  endtask

  task automatic test_tie_reset();
    doReset();
    pulseLanes(8'h12, 7);
    doCycle();
    vectors++;
    if (busiest !== 8'b0000_0010) begin
      errors++;
      $display("[TB] FAIL tie_busiest: got %b expected %b", busiest, 8'b0000_0010);
    end
    vectors++;
    if (total !== 11'd14) begin
      errors++;
      $display("[TB] FAIL tie_total: got %0d expected %0d", total, 14);
    end
    green = 8'hFF;
    for (int k = 0; k < 5; k++) doCycle();
    vectors++;
    if (lanes[15:8] !== 8'd6) begin
      errors++;
      $display("[TB] FAIL tie_departed: got %0d expected %0d", lanes[15:8], 6);
    end
    rst = 1'b0;
    doCycle();
    rst = 1'b1;
    vectors++;
    if (lanes !== 64'h0) begin
      errors++;
      $display("[TB] FAIL midrst_lanes: got %h expected %h", lanes, 64'h0);
    end
    vectors++;
    if (busiest !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_busiest: got %b expected %b", busiest, 8'h00);
    end
    vectors++;
    if (total !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midrst_total: got %0d expected %0d", total, 0);
    end
    green = 8'h00;
    doCycle();
    vectors++;
    if (lanes !== expLanes()) begin
      errors++;
      $display("[TB] FAIL midrst_after: got %h expected %h", lanes, expLanes());
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 3200; c++) begin
      sensor = 8'($urandom);
      if (c < 1200) begin
        green      = 8'($urandom & $urandom & $urandom);
        clear_lane = 8'h00;
        rst        = 1'b1;
      end else begin
        green      = 8'($urandom | $urandom);
        clear_lane = ($urandom_range(0, 31) == 0) ? 8'($urandom & $urandom) : 8'h00;
        rst        = ($urandom_range(0, 299) != 0);
      end
      doCycle();
      vectors++;
      if (lanes !== expLanes()) begin
        errors++;
        $display("[TB] FAIL rand_lanes cyc %0d: got %h expected %h", c, lanes, expLanes());
      end
      vectors++;
      if (busiest !== mBusy) begin
        errors++;
        $display("[TB] FAIL rand_busiest cyc %0d: got %b expected %b", c, busiest, mBusy);
      end
      vectors++;
      if (total !== 11'(mTot)) begin
        errors++;
        $display("[TB] FAIL rand_total cyc %0d: got %0d expected %0d", c, total, mTot);
      end
`ifdef LANE_OVF_FLAG_EN
      vectors++;
      if (ovf !== mOvf) begin
        errors++;
        $display("[TB] FAIL rand_ovf cyc %0d: got %b expected %b", c, ovf, mOvf);
      end
`endif
    end
    rst        = 1'b1;
    sensor     = 8'h00;
    green      = 8'h00;
    clear_lane = 8'h00;
  endtask

  // Scenario sequence and summary
  initial begin
    vectors    = 0;
    errors     = 0;
    rst        = 1'b0;
    sensor     = 8'h00;
    green      = 8'h00;
    clear_lane = 8'h00;
    test_reset();
    test_arrivals();
    test_departure();
    test_simultaneous();
    test_saturation();
    test_tie_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
